score_reporter: RTL and testbench
=================================

# score_reporter

Transmit-side companion to the game control block. It turns game events (start, score increments, game over, and optionally the countdown) into short ASCII lines and drives the transmit half of the shared `uart` instance: `transmit`, `tx_byte` and `is_transmitting`. It sits between the score/state logic and the UART, so a terminal attached to the board sees the game progress. It never blocks gameplay: events that arrive while a line is in flight are held as pending and coalesced.

## Interface
- `COUNT_W`, default 8: width of `count_down`.
- `ACK_TIMEOUT`, default 4: cycles to wait for `is_transmitting` to rise after a `transmit` pulse.
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `reset_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: game running flag.
- `over`, in, 1: game over flag.
- `score`, in, 16: four BCD digits; [15:12] is the most significant.
- `score_inc`, in, 1: one-cycle pulse when the score changes.
- `count_down`, in, COUNT_W: remaining seconds, binary.
- `is_transmitting`, in, 1: UART busy.
- `transmit`, out, 1: one-cycle strobe that loads `tx_byte` into the UART.
- `tx_byte`, out, 8: byte to send.
- `busy`, out, 1: a line is being emitted.

## Operation
- Event detect, using registered previous values:
  - rising edge of `start` sets `pend_go`;
  - rising edge of `over` sets `pend_over`;
  - `score_inc` sets `pend_score`.
  - Setting a flag that is already set has no effect (coalescing).
- Lines:
  - GO: "GO\r\n".
  - SCORE: "S:" + 4 digits + "\r\n".
  - OVER: "OVER " + 4 digits + "\r\n".
  - Each digit is sent as ASCII '0'+d. A nibble greater than 9 is sent as '?' (8'h3F).
- Priority when several flags are pending: OVER, then GO, then SCORE.
- The winning flag is cleared in the same cycle as the LOAD state.
- `pend_go` rising in the same cycle as `pend_over` discards GO.
- `score` is snapshotted in LOAD. Later changes do not alter a line in flight; they are reported by the next SCORE line.
- FSM:
  - IDLE: go to LOAD if any flag is pending.
  - LOAD: latch the message type, the score snapshot and idx=0.
  - SEND: pulse `transmit` with `tx_byte` = char[idx], then go to ACK.
  - ACK: wait for `is_transmitting`=1, or for ACK_TIMEOUT cycles, then go to DRAIN.
  - DRAIN: wait for `is_transmitting`=0. If this was the last character, go to IDLE; otherwise idx++ and go to SEND.
- SEND is entered only when `is_transmitting`=0.
- A new event during any non-IDLE state only sets its flag. The current line always completes.
- `busy` = 1 in every state except IDLE.

## Timing
- Reset values: `transmit`=0, `tx_byte`=8'h00, `busy`=0, state=IDLE, all flags=0.
- Reset asserted mid-line aborts the line at once. Outputs take their reset values asynchronously.
- Latency with an idle UART: event on cycle t, flag set at t+1, LOAD at t+1, first `transmit` pulse at t+2.
- `transmit` is high for exactly 1 cycle per byte.
- `tx_byte` stays stable from the pulse until the following DRAIN exit.
- Throughput is one byte per UART frame plus 2 cycles (DRAIN to SEND to ACK).
- Simultaneous `score_inc` and an OVER edge in the same cycle: OVER is sent first, then SCORE.

## Configuration
- `SCORE_REPORTER_COUNTDOWN_EN` defined:
  - Adds a `pend_time` flag, set whenever `count_down` differs from its previous value while `start`=1.
  - Line: "T:" + 3 decimal digits + "\r\n". It has the lowest priority.
  - LOAD starts a `bin2bcd3` conversion. SEND for TIME waits for the converter's done signal.
  - `count_down` values of 1000 or more saturate to "999".
- Macro undefined: no TIME lines. `count_down` is unused and the converter is not instantiated.

## Structure
- Package `enum_type` gains `msg_type` (MSG_GO, MSG_SCORE, MSG_OVER, MSG_TIME) and the ASCII constants CR=8'h0D, LF=8'h0A.
- Sub-module `bin2bcd3`: sequential double-dabble converter.
  - One bit per cycle, COUNT_W cycles.
  - Ports: clk, reset_n, go, bin, bcd[11:0], done.
- The character selector is a combinational function of (type, idx, snapshot).

## Test plan
- `start` goes 0 to 1 with the UART model busy for 10 cycles per byte → bytes 47 4F 0D 0A, `transmit` pulses spaced by at least 10 cycles.
- `score`=16'h0123 with a `score_inc` pulse → "S:0123\r\n"; `transmit` first rises 2 cycles after the pulse.
- Three `score_inc` pulses during an in-flight SCORE line, score finally 16'h0042 → exactly one further line, "S:0042\r\n".
- `over` edge and `score_inc` in the same cycle, score=16'h0007 → "OVER 0007\r\n" then "S:0007\r\n".
- `score`=16'h00A5 → digits "00?5"; `is_transmitting` held 0 → each byte advances after ACK_TIMEOUT=4 cycles.
- `reset_n` low after the 3rd byte → `transmit`=0 and `busy`=0 immediately, no further bytes. With the macro defined, `count_down` going 30 to 29 → "T:029\r\n".

Source files
------------

// File: rtl/score_reporter_pkg.sv
// Shared types, ASCII constants and the line character selector for score_reporter.
package score_reporter_pkg;

   typedef enum logic [1:0] {MSG_GO, MSG_SCORE, MSG_OVER, MSG_TIME} msg_type;

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_ACK, ST_DRAIN} state_t;

   localparam logic [7:0] CR       = 8'h0D;
   localparam logic [7:0] LF       = 8'h0A;
   localparam logic [7:0] CH_QMARK = 8'h3F;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return (d > 4'd9) ? CH_QMARK : (8'h30 + {4'h0, d});
   endfunction

   // k = 0 selects the most significant nibble.
   function automatic logic [3:0] bcd_digit(input logic [15:0] v, input logic [1:0] k);
      logic [15:0] s;
      s = v << {k, 2'b00};
      return s[15:12];
   endfunction

   function automatic logic [3:0] last_idx(input msg_type t);
      logic [3:0] n;
      case (t)
         MSG_GO:    n = 4'd3;
         MSG_SCORE: n = 4'd7;
         MSG_OVER:  n = 4'd10;
         default:   n = 4'd6;
      endcase
      return n;
   endfunction

   function automatic logic [7:0] line_char(input msg_type t, input logic [3:0] idx,
                                            input logic [15:0] snap, input logic [11:0] tbcd);
      logic [7:0] c;
      c = 8'h00;
      case (t)
         MSG_GO: begin
            case (idx)
               4'd0:    c = "G";
               4'd1:    c = "O";
               4'd2:    c = CR;
               4'd3:    c = LF;
               default: c = 8'h00;
            endcase
         end
         MSG_SCORE: begin
            case (idx)
               4'd0:                   c = "S";
               4'd1:                   c = ":";
               4'd2, 4'd3, 4'd4, 4'd5: c = digit_char(bcd_digit(snap, 2'(idx - 4'd2)));
               4'd6:                   c = CR;
               4'd7:                   c = LF;
               default:                c = 8'h00;
            endcase
         end
         MSG_OVER: begin
            case (idx)
               4'd0:                   c = "O";
               4'd1:                   c = "V";
               4'd2:                   c = "E";
               4'd3:                   c = "R";
               4'd4:                   c = " ";
               4'd5, 4'd6, 4'd7, 4'd8: c = digit_char(bcd_digit(snap, 2'(idx - 4'd5)));
               4'd9:                   c = CR;
               4'd10:                  c = LF;
               default:                c = 8'h00;
            endcase
         end
         default: begin
            case (idx)
               4'd0:             c = "T";
               4'd1:             c = ":";
               4'd2, 4'd3, 4'd4: c = digit_char(bcd_digit({tbcd, 4'h0}, 2'(idx - 4'd2)));
               4'd5:             c = CR;
               4'd6:             c = LF;
               default:          c = 8'h00;
            endcase
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/score_reporter_if.sv
// UART transmit handshake shared between score_reporter (master) and the UART (slave).
interface score_reporter_if;
   logic       transmit;
   logic [7:0] tx_byte;
   logic       is_transmitting;

   modport master (output transmit, output tx_byte, input is_transmitting);
   modport slave  (input transmit, input tx_byte, output is_transmitting);
endinterface

// File: rtl/score_reporter_bin2bcd3.sv
// bin2bcd3: sequential double-dabble, one bit per cycle, three BCD digits saturating at 999.
module bin2bcd3 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         go,
   input  logic [W-1:0] bin,
   output logic [11:0]  bcd,
   output logic         done
);
   localparam int CW = $clog2(W + 1);

   logic [11+W:0] sh_q, sh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sat_q, sat_d;
   logic          done_q, done_d;
   logic [11:0]   adj;

   for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (sh_q[W+4*gi +: 4] >= 4'd5) ? sh_q[W+4*gi +: 4] + 4'd3
                                                          : sh_q[W+4*gi +: 4];
   end

   always_comb begin
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      sat_d  = sat_q;
      done_d = done_q;
      if (go) begin
         sh_d   = {12'h000, bin};
         cnt_d  = CW'(W);
         sat_d  = (32'(bin) >= 32'd1000);
         done_d = 1'b0;
      end else if (cnt_q != '0) begin
         sh_d  = {adj, sh_q[W-1:0]} << 1;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         sat_q  <= sat_d;
         done_q <= done_d;
      end
   end

   assign bcd  = sat_q ? 12'h999 : sh_q[11+W:W];
   assign done = done_q;
endmodule

// File: rtl/score_reporter.sv
// score_reporter: turns game events into short ASCII lines on the UART transmit port.
// Define SCORE_REPORTER_COUNTDOWN_EN to add "T:nnn" countdown lines (lowest priority).
module score_reporter
   import score_reporter_pkg::*;
#(
   parameter int COUNT_W     = 8,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               over,
   input  logic [15:0]        score,
   input  logic               score_inc,
   input  logic [COUNT_W-1:0] count_down,
   output logic               busy,
   score_reporter_if.master   uart
);
   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

   state_t           state_q, state_d;
   msg_type          type_q, type_d;
   logic [15:0]      snap_q, snap_d;
   logic [3:0]       idx_q, idx_d;
   logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
   logic             start_prev_q, over_prev_q;
   logic             pend_go_q, pend_go_d;
   logic             pend_over_q, pend_over_d;
   logic             pend_score_q, pend_score_d;
   logic             go_set, over_set, score_set, any_pend, any_set;
   logic             clr_go, clr_over, clr_score;
   logic             char_ready;
   logic [11:0]      time_bcd;

`ifdef SCORE_REPORTER_COUNTDOWN_EN
   logic [COUNT_W-1:0] count_prev_q;
   logic               pend_time_q, pend_time_d;
   logic               time_set, clr_time, conv_go, conv_done;

   bin2bcd3 #(.W(COUNT_W)) u_bin2bcd3 (
      .clk     (clk),
      .reset_n (reset_n),
      .go      (conv_go),
      .bin     (count_down),
      .bcd     (time_bcd),
      .done    (conv_done)
   );

   assign time_set   = start & (count_down != count_prev_q);
   assign char_ready = (type_q != MSG_TIME) | conv_done;
`else
   logic unused_count_down;
   assign unused_count_down = ^count_down;
   assign time_bcd          = 12'h000;
   assign char_ready        = 1'b1;
`endif

   always_comb begin
      over_set  = over & ~over_prev_q;
      go_set    = start & ~start_prev_q & ~over_set;
      score_set = score_inc;
      any_pend  = pend_go_q | pend_over_q | pend_score_q;
      any_set   = go_set | over_set | score_set;
`ifdef SCORE_REPORTER_COUNTDOWN_EN
      any_pend  = any_pend | pend_time_q;
      any_set   = any_set | time_set;
      clr_time  = 1'b0;
      conv_go   = 1'b0;
`endif
      state_d       = state_q;
      type_d        = type_q;
      snap_d        = snap_q;
      idx_d         = idx_q;
      ack_cnt_d     = ack_cnt_q;
      clr_go        = 1'b0;
      clr_over      = 1'b0;
      clr_score     = 1'b0;
      uart.transmit = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_pend | any_set) begin
               state_d = ST_LOAD;
            end
         end
         // Commit happens on the exit cycle so the UART is known idle when SEND starts.
         ST_LOAD: begin
            if (!uart.is_transmitting) begin
               idx_d   = 4'd0;
               snap_d  = score;
               state_d = ST_SEND;
               if (pend_over_q) begin
                  type_d   = MSG_OVER;
                  clr_over = 1'b1;
               end else if (pend_go_q) begin
                  type_d = MSG_GO;
                  clr_go = 1'b1;
               end else if (pend_score_q) begin
                  type_d    = MSG_SCORE;
                  clr_score = 1'b1;
               end
`ifdef SCORE_REPORTER_COUNTDOWN_EN
               else if (pend_time_q) begin
                  type_d   = MSG_TIME;
                  clr_time = 1'b1;
                  conv_go  = 1'b1;
               end
`endif
               else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_SEND: begin
            if (char_ready) begin
               uart.transmit = 1'b1;
               ack_cnt_d     = '0;
               state_d       = ST_ACK;
            end
         end
         ST_ACK: begin
            if (uart.is_transmitting || (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1))) begin
               state_d = ST_DRAIN;
            end else begin
               ack_cnt_d = ack_cnt_q + ACK_W'(1);
            end
         end
         ST_DRAIN: begin
            if (!uart.is_transmitting) begin
               if (idx_q == last_idx(type_q)) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = ST_SEND;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A new event in the commit cycle survives the clear of its own flag.
      pend_go_d    = (pend_go_q & ~clr_go) | go_set;
      pend_over_d  = (pend_over_q & ~clr_over) | over_set;
      pend_score_d = (pend_score_q & ~clr_score) | score_set;
`ifdef SCORE_REPORTER_COUNTDOWN_EN
      pend_time_d  = (pend_time_q & ~clr_time) | time_set;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         type_q       <= MSG_GO;
         snap_q       <= '0;
         idx_q        <= '0;
         ack_cnt_q    <= '0;
         start_prev_q <= 1'b0;
         over_prev_q  <= 1'b0;
         pend_go_q    <= 1'b0;
         pend_over_q  <= 1'b0;
         pend_score_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         type_q       <= type_d;
         snap_q       <= snap_d;
         idx_q        <= idx_d;
         ack_cnt_q    <= ack_cnt_d;
         start_prev_q <= start;
         over_prev_q  <= over;
         pend_go_q    <= pend_go_d;
         pend_over_q  <= pend_over_d;
         pend_score_q <= pend_score_d;
      end
   end

`ifdef SCORE_REPORTER_COUNTDOWN_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_prev_q <= '0;
         pend_time_q  <= 1'b0;
      end else begin
         count_prev_q <= count_down;
         pend_time_q  <= pend_time_d;
      end
   end
`endif

   assign busy         = (state_q != ST_IDLE);
   assign uart.tx_byte = (state_q == ST_SEND || state_q == ST_ACK || state_q == ST_DRAIN)
                         ? line_char(type_q, idx_q, snap_q, time_bcd) : 8'h00;
endmodule

// File: tb/tb_score_reporter.sv
// Testbench for score_reporter: random events against a line-level reference model plus directed cases.
`timescale 1ns/1ps
module tb_score_reporter;
   localparam int COUNT_W     = 8;
   localparam int ACK_TIMEOUT = 4;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               start = 1'b0;
   logic               over = 1'b0;
   logic [15:0]        score = 16'h0000;
   logic               score_inc = 1'b0;
   logic [COUNT_W-1:0] count_down = '0;
   logic               busy;

   score_reporter_if uart_if ();

   score_reporter #(.COUNT_W(COUNT_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .over       (over),
      .score      (score),
      .score_inc  (score_inc),
      .count_down (count_down),
      .busy       (busy),
      .uart       (uart_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // UART model: busy for frame_len cycles after each load strobe.
   int frame_len = 0;
   int uart_cnt  = 0;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)                uart_cnt <= 0;
      else if (uart_if.transmit)   uart_cnt <= frame_len;
      else if (uart_cnt > 0)       uart_cnt <= uart_cnt - 1;
   end
   assign uart_if.is_transmitting = (uart_cnt != 0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic string dig(input logic [3:0] n);
      if (n > 4'd9) return "?";
      return $sformatf("%0d", n);
   endfunction

   function automatic string four(input logic [15:0] v);
      return {dig(v[15:12]), dig(v[11:8]), dig(v[7:4]), dig(v[3:0])};
   endfunction

   // Reference model: pending sets, and the byte queue of the line in flight.
   logic [7:0]  cap_q[$];
   int          cap_cyc[$];
   logic [7:0]  exp_q[$];
   bit          m_go, m_over, m_score;
   bit          e_go, e_over, e_score;
   bit          sp, op, tx_last;
   bit          model_on = 1'b1;
   logic [15:0] score_last;

   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         m_go = 0; m_over = 0; m_score = 0;
         e_go = 0; e_over = 0; e_score = 0;
         sp = 0; op = 0; tx_last = 0;
         score_last = score;
      end else begin
         if (uart_if.transmit) begin
            cap_q.push_back(uart_if.tx_byte);
            cap_cyc.push_back(cyc);
         end
         if (model_on && uart_if.transmit) begin
            check("tx_single_cycle", {31'd0, tx_last}, 0);
            if (exp_q.size() == 0) begin
               string ln;
               // Line chosen from events up to two cycles back; score as of the commit cycle.
               if (m_over)       begin ln = {"OVER ", four(score_last), "\r\n"}; m_over = 0;  end
               else if (m_go)    begin ln = "GO\r\n";                             m_go = 0;    end
               else if (m_score) begin ln = {"S:", four(score_last), "\r\n"};    m_score = 0; end
               else              begin ln = ""; end
               check("line_has_pending_event", (ln.len() != 0) ? 32'd1 : 32'd0, 1);
               for (int i = 0; i < ln.len(); i++) exp_q.push_back(ln[i]);
            end
            if (exp_q.size() > 0) check("tx_byte", uart_if.tx_byte, exp_q.pop_front());
         end
         if (model_on && exp_q.size() > 0) check("busy_mid_line", {31'd0, busy}, 1);
         m_go    |= e_go;
         m_over  |= e_over;
         m_score |= e_score;
         e_over  = over && !op;
         e_go    = start && !sp && !e_over;
         e_score = score_inc;
         sp = start;
         op = over;
         score_last = score;
         tx_last = uart_if.transmit;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_score(input logic [15:0] v);
      score = v;
      score_inc = 1'b1;
      tick(1);
      score_inc = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 0;
      tick(3);
      for (int i = 0; i < 3000 && !done; i++) begin
         if (!busy && exp_q.size() == 0 && !(m_go | m_over | m_score | e_go | e_over | e_score))
            done = 1;
         else
            tick(1);
      end
      check({name, "_drained"}, {31'd0, done}, 1);
   endtask

   task automatic wait_bytes(input int n);
      int i;
      for (i = 0; i < 3000 && cap_q.size() < n; i++) tick(1);
      check("wait_bytes_bound", (cap_q.size() >= n) ? 32'd1 : 32'd0, 1);
   endtask

   task automatic wait_quiet();
      int idle;
      idle = 0;
      for (int i = 0; i < 3000 && idle < 20; i++) begin
         tick(1);
         idle = busy ? 0 : idle + 1;
      end
      check("quiet_bound", (idle >= 20) ? 32'd1 : 32'd0, 1);
   endtask

   task automatic expect_str(input string name, input int from, input string s);
      check({name, "_len"}, cap_q.size() - from, s.len());
      for (int i = 0; i < s.len() && from + i < cap_q.size(); i++)
         check(name, cap_q[from+i], s[i]);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int mark, ev;
      logic [15:0] later[3];
      later = '{16'h0020, 16'h0031, 16'h0042};

      tick(3);
      check("rst_transmit", {31'd0, uart_if.transmit}, 0);
      check("rst_tx_byte", {24'd0, uart_if.tx_byte}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      reset_n = 1'b1;
      tick(3);
      check("idle_busy", {31'd0, busy}, 0);

      // GO line with a 10-cycle UART frame
      frame_len = 10;
      mark = cap_q.size();
      start = 1'b1;
      ev = cyc;
      tick(1);
      wait_idle("go");
      expect_str("go_line", mark, "GO\r\n");
      if (cap_q.size() > mark) check("go_latency", cap_cyc[mark] - ev, 2);
      for (int i = mark; i + 1 < cap_q.size(); i++)
         check("go_gap_ge10", (cap_cyc[i+1] - cap_cyc[i] >= 10) ? 32'd1 : 32'd0, 1);

      // SCORE line and its latency
      mark = cap_q.size();
      ev = cyc;
      pulse_score(16'h0123);
      wait_idle("score");
      expect_str("score_line", mark, "S:0123\r\n");
      if (cap_q.size() > mark) check("score_latency", cap_cyc[mark] - ev, 2);

      // Three increments during an in-flight line coalesce into one more line
      mark = cap_q.size();
      pulse_score(16'h0011);
      wait_bytes(mark + 1);
      for (int i = 0; i < 3; i++) begin
         tick(5);
         pulse_score(later[i]);
      end
      wait_idle("coalesce");
      expect_str("coalesce_lines", mark, "S:0011\r\nS:0042\r\n");

      // OVER edge and score_inc together: OVER first
      mark = cap_q.size();
      over = 1'b1;
      pulse_score(16'h0007);
      wait_idle("over");
      expect_str("over_then_score", mark, "OVER 0007\r\nS:0007\r\n");
      over = 1'b0;
      tick(2);

      // Non-decimal nibble and ACK timeout pacing with a silent UART
      frame_len = 0;
      mark = cap_q.size();
      pulse_score(16'h00A5);
      wait_idle("qmark");
      expect_str("qmark_line", mark, "S:00?5\r\n");
      for (int i = mark; i + 1 < cap_q.size(); i++)
         check("timeout_gap", cap_cyc[i+1] - cap_cyc[i], ACK_TIMEOUT + 2);

      // Reset in the middle of a line
      frame_len = 3;
      mark = cap_q.size();
      over = 1'b1;
      tick(1);
      wait_bytes(mark + 3);
      check("busy_before_reset", {31'd0, busy}, 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_transmit", {31'd0, uart_if.transmit}, 0);
      check("async_rst_busy", {31'd0, busy}, 0);
      check("async_rst_tx_byte", {24'd0, uart_if.tx_byte}, 0);
      over = 1'b0;
      start = 1'b0;
      tick(3);
      reset_n = 1'b1;
      mark = cap_q.size();
      tick(40);
      check("no_bytes_after_reset", cap_q.size() - mark, 0);
      check("idle_after_reset", {31'd0, busy}, 0);

      // Random events against the model
      for (int i = 0; i < 3000; i++) begin
         score_inc = ($urandom_range(0, 7) == 0);
         if (score_inc) score = 16'($urandom);
         if ($urandom_range(0, 29) == 0) start = ~start;
         if ($urandom_range(0, 49) == 0) over = ~over;
         frame_len = $urandom_range(0, 12);
         tick(1);
      end
      score_inc = 1'b0;
      wait_idle("random");

`ifdef SCORE_REPORTER_COUNTDOWN_EN
      model_on = 1'b0;
      frame_len = 2;
      start = 1'b0;
      count_down = 8'd30;
      wait_quiet();
      start = 1'b1;
      tick(1);
      wait_quiet();
      mark = cap_q.size();
      count_down = 8'd29;
      tick(1);
      wait_quiet();
      expect_str("time_line", mark, "T:029\r\n");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
